debug_step_unit: RTL and testbench
==================================

DEBUG_STEP_UNIT -- requirements
Module: debug_step_unit

Interface
REQ-001 Parameter NB, default 32, data and PC width.
REQ-002 Parameter NB_CNT, default 16, step-count width.
REQ-003 Parameter N_REGS, default 32, number of MIPS registers dumped (max 32).
REQ-004 Parameter TAM_DATA_MEMORY, default 16, number of data-memory words dumped.
REQ-005 i_clk  input  1  single clock; all state changes on rising edge.
REQ-006 i_reset  input  1  synchronous, active-high reset.
REQ-007 i_cmd_valid  input  1  command offered.
REQ-008 i_cmd  input  2  command: 00 STOP, 01 RUN, 10 STEP_N, 11 DUMP.
REQ-009 i_cmd_arg  input  NB_CNT  step count N for STEP_N.
REQ-010 o_cmd_ready  output  1  command accepted when i_cmd_valid and o_cmd_ready are both high at a rising edge.
REQ-011 i_bp_enable  input  1  breakpoint enable.
REQ-012 i_bp_pc  input  NB  breakpoint PC.
REQ-013 i_mips_pc  input  NB  pipeline PC.
REQ-014 i_mips_register_data  input  NB  pipeline debug register read data (combinational from address).
REQ-015 i_mips_data_memory  input  NB  pipeline debug memory read data (combinational from address).
REQ-016 o_step  output  1  pipeline advance enable.
REQ-017 o_debug_mips_register_number  output  5  register index to pipeline.
REQ-018 o_debug_address  output  NB  byte address to pipeline.
REQ-019 o_dump_data, o_dump_valid, i_dump_ready  output NB / output 1 / input 1  dump stream; word transfers when valid and ready are both high at an edge.
REQ-020 o_halted_bp  output  1  last run ended on breakpoint.
REQ-021 o_busy  output  1  state is not IDLE.

Function
REQ-022 The FSM SHALL have states IDLE, RUN, STEP, DUMP_REG, DUMP_MEM.
REQ-023 o_cmd_ready SHALL be high in IDLE, RUN and STEP, and low in DUMP_REG and DUMP_MEM.
REQ-024 In IDLE, an accepted RUN command SHALL go to RUN, STEP_N SHALL load the counter with i_cmd_arg and go to STEP, DUMP SHALL go to DUMP_REG with index 0, and STOP SHALL have no effect.
REQ-025 In RUN and STEP, an accepted STOP SHALL return to IDLE at that edge; other accepted commands SHALL be discarded without effect.
REQ-026 o_step SHALL be combinational: high only in RUN or STEP and not bp_hit, where bp_hit = i_bp_enable and (i_mips_pc == i_bp_pc).
REQ-027 RUN SHALL hold o_step high every cycle until STOP or bp_hit; on bp_hit it SHALL go to IDLE and set o_halted_bp.
REQ-028 STEP SHALL assert o_step for exactly N cycles, decrementing the counter each cycle, then return to IDLE.
REQ-029 STEP with N = 0 SHALL assert no o_step and return to IDLE on the next edge.
REQ-030 A breakpoint hit in STEP SHALL end STEP early the same way as in RUN.
REQ-031 o_halted_bp SHALL clear on the next accepted command.
REQ-032 In DUMP_REG, o_debug_mips_register_number SHALL equal the index, o_dump_data SHALL equal i_mips_register_data, and o_dump_valid SHALL be high.
REQ-033 In DUMP_REG, the index SHALL advance only on a transfer; after index N_REGS-1 transfers, the state SHALL go to DUMP_MEM with index 0.
REQ-034 In DUMP_MEM, o_debug_address SHALL equal index*4 and o_dump_data SHALL equal i_mips_data_memory.
REQ-035 In DUMP_MEM, after index TAM_DATA_MEMORY-1 transfers, the state SHALL return to IDLE.
REQ-036 While o_dump_valid is high and i_dump_ready is low, the address and data SHALL be held stable.
REQ-037 o_step SHALL be low throughout DUMP states, so the pipeline state is frozen during a dump.
REQ-038 o_dump_valid SHALL be low outside DUMP states.
REQ-039 Outside DUMP states, the debug address outputs SHALL hold their last value.

Reset
REQ-040 On i_reset, the state SHALL be IDLE and the counter and index SHALL be 0.
REQ-041 On i_reset, o_step, o_dump_valid, o_halted_bp and o_busy SHALL be 0.
REQ-042 On i_reset, o_debug_mips_register_number and o_debug_address SHALL be 0.
REQ-043 On i_reset, o_cmd_ready SHALL be 1 on the cycle after reset is released.
REQ-044 Reset asserted mid-RUN, mid-STEP or mid-dump SHALL abort the operation, with o_step and o_dump_valid low from the next edge.

Verification
REQ-045 STEP_N with N=4 from PC 0 -> o_step high exactly 4 cycles, PC=16, then IDLE and o_busy=0.
REQ-046 RUN with i_bp_enable=1 and i_bp_pc=20 -> o_step low while PC=20, o_halted_bp=1, PC stays 20 for 10 idle cycles.
REQ-047 DUMP with i_dump_ready always high -> 48 consecutive valid words: registers 0..31, then memory addresses 0..60 step 4; register 4 word equals $5+$3 after ADD $4,$5,$3 completes.
REQ-048 DUMP with i_dump_ready toggling 1,0,0,1 -> no word lost or duplicated, and address/data stable while stalled.
REQ-049 STEP_N with N=0 -> no o_step pulse, back in IDLE next cycle; RUN followed by STOP after 3 cycles -> exactly 3 o_step cycles.
REQ-050 Reset asserted at word 10 of a DUMP -> o_dump_valid=0 next cycle, IDLE, and the next DUMP restarts at register 0.

Source files
------------

// File: rtl/debug_step_unit_if.sv
// Command, breakpoint, pipeline-debug and dump-stream signals of debug_step_unit.
// slave: the step unit itself; master: the host/pipeline side driving it.
interface debug_step_unit_if #(
  parameter int unsigned NB     = 32,
  parameter int unsigned NB_CNT = 16
);
  logic              i_cmd_valid;
  logic [1:0]        i_cmd;
  logic [NB_CNT-1:0] i_cmd_arg;
  logic              o_cmd_ready;
  logic              i_bp_enable;
  logic [NB-1:0]     i_bp_pc;
  logic [NB-1:0]     i_mips_pc;
  logic [NB-1:0]     i_mips_register_data;
  logic [NB-1:0]     i_mips_data_memory;
  logic              o_step;
  logic [4:0]        o_debug_mips_register_number;
  logic [NB-1:0]     o_debug_address;
  logic [NB-1:0]     o_dump_data;
  logic              o_dump_valid;
  logic              i_dump_ready;
  logic              o_halted_bp;
  logic              o_busy;

  modport slave (
    input  i_cmd_valid, i_cmd, i_cmd_arg, i_bp_enable, i_bp_pc, i_mips_pc,
           i_mips_register_data, i_mips_data_memory, i_dump_ready,
    output o_cmd_ready, o_step, o_debug_mips_register_number, o_debug_address,
           o_dump_data, o_dump_valid, o_halted_bp, o_busy
  );

  modport master (
    output i_cmd_valid, i_cmd, i_cmd_arg, i_bp_enable, i_bp_pc, i_mips_pc,
           i_mips_register_data, i_mips_data_memory, i_dump_ready,
    input  o_cmd_ready, o_step, o_debug_mips_register_number, o_debug_address,
           o_dump_data, o_dump_valid, o_halted_bp, o_busy
  );
endinterface

// File: rtl/debug_step_unit.sv
// Debug controller for a MIPS pipeline: free run with breakpoint, N-step, and a
// register-file plus data-memory dump streamed out over a valid/ready channel.
module debug_step_unit #(
  parameter int unsigned NB              = 32,
  parameter int unsigned NB_CNT          = 16,
  parameter int unsigned N_REGS          = 32,
  parameter int unsigned TAM_DATA_MEMORY = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  debug_step_unit_if.slave  bus
);

  // Index must cover both the 32 register slots and the memory word count.
  localparam int unsigned IdxW = (TAM_DATA_MEMORY > 32) ? $clog2(TAM_DATA_MEMORY) : 5;

  localparam logic [1:0] CmdStop = 2'b00;
  localparam logic [1:0] CmdRun  = 2'b01;
  localparam logic [1:0] CmdStep = 2'b10;
  localparam logic [1:0] CmdDump = 2'b11;

  typedef enum logic [2:0] {StIdle, StRun, StStep, StDumpReg, StDumpMem} state_e;

  state_e            state_q, state_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              halted_q, halted_d;
  logic [4:0]        reg_num_q, reg_num_d;
  logic [NB-1:0]     addr_q, addr_d;

  logic bp_hit;
  logic cmd_fire;
  logic dump_fire;
  logic is_stop;

  assign bp_hit    = bus.i_bp_enable && (bus.i_mips_pc == bus.i_bp_pc);
  assign cmd_fire  = bus.i_cmd_valid && bus.o_cmd_ready;
  assign dump_fire = bus.o_dump_valid && bus.i_dump_ready;
  assign is_stop   = cmd_fire && (bus.i_cmd == CmdStop);

  assign bus.o_halted_bp                  = halted_q;
  assign bus.o_busy                       = (state_q != StIdle);
  assign bus.o_debug_mips_register_number = reg_num_q;
  assign bus.o_debug_address              = addr_q;

  // State-decoded outputs; o_step is gated by the breakpoint in the same cycle.
  always_comb begin
    bus.o_cmd_ready  = 1'b0;
    bus.o_step       = 1'b0;
    bus.o_dump_valid = 1'b0;
    bus.o_dump_data  = '0;
    case (state_q)
      StIdle: bus.o_cmd_ready = 1'b1;
      StRun: begin
        bus.o_cmd_ready = 1'b1;
        bus.o_step      = !bp_hit;
      end
      StStep: begin
        bus.o_cmd_ready = 1'b1;
        bus.o_step      = (cnt_q != '0) && !bp_hit;
      end
      StDumpReg: begin
        bus.o_dump_valid = 1'b1;
        bus.o_dump_data  = bus.i_mips_register_data;
      end
      StDumpMem: begin
        bus.o_dump_valid = 1'b1;
        bus.o_dump_data  = bus.i_mips_data_memory;
      end
      default: ;
    endcase
  end

  // Next-state logic; debug address/register number only move on a dump transfer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    halted_d  = halted_q;
    reg_num_d = reg_num_q;
    addr_d    = addr_q;
    if (cmd_fire) halted_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          case (bus.i_cmd)
            CmdRun:  state_d = StRun;
            CmdStep: begin
              cnt_d   = bus.i_cmd_arg;
              state_d = StStep;
            end
            CmdDump: begin
              idx_d     = '0;
              reg_num_d = '0;
              state_d   = StDumpReg;
            end
            default: ;
          endcase
        end
      end
      StRun: begin
        if (is_stop) begin
          state_d = StIdle;
        end else if (bp_hit) begin
          state_d  = StIdle;
          halted_d = 1'b1;
        end
      end
      StStep: begin
        if (is_stop || (cnt_q == '0)) begin
          state_d = StIdle;
        end else if (bp_hit) begin
          state_d  = StIdle;
          halted_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          // Leave on the edge that ends the last step so no dead cycle follows.
          if (cnt_q == NB_CNT'(1)) state_d = StIdle;
        end
      end
      StDumpReg: begin
        if (dump_fire) begin
          if (idx_q == IdxW'(N_REGS - 1)) begin
            idx_d   = '0;
            addr_d  = '0;
            state_d = StDumpMem;
          end else begin
            idx_d     = idx_q + 1'b1;
            reg_num_d = 5'(idx_q + 1'b1);
          end
        end
      end
      StDumpMem: begin
        if (dump_fire) begin
          if (idx_q == IdxW'(TAM_DATA_MEMORY - 1)) begin
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d  = idx_q + 1'b1;
            addr_d = NB'(idx_q + 1'b1) << 2;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      halted_q  <= 1'b0;
      reg_num_q <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      halted_q  <= halted_d;
      reg_num_q <= reg_num_d;
      addr_q    <= addr_d;
    end
  end

endmodule

// File: tb/tb_debug_step_unit.sv
// Bench for debug_step_unit: a tiny pipeline model (PC += 4 per step, one ADD at
// PC 8) plus a scoreboard of expected dump words checked by a separate monitor.
module tb_debug_step_unit;

  localparam logic [1:0] CmdStop = 2'b00;
  localparam logic [1:0] CmdRun  = 2'b01;
  localparam logic [1:0] CmdStep = 2'b10;
  localparam logic [1:0] CmdDump = 2'b11;

  typedef struct packed {
    logic        is_mem;
    logic [31:0] data;
    logic [4:0]  rn;
    logic [31:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debug_step_unit_if #(.NB(32), .NB_CNT(16)) bus ();

  debug_step_unit #(
    .NB(32), .NB_CNT(16), .N_REGS(32), .TAM_DATA_MEMORY(16)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Pipeline model
  logic [31:0] pc;
  logic [31:0] regs [32];
  logic        model_init;
  logic        pc_load;
  logic [31:0] pc_val;

  always @(posedge clk) begin
    if (model_init) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'hA000_0000 + i;
    end
    if (pc_load) begin
      pc <= pc_val;
    end else if (bus.o_step) begin
      pc <= pc + 32'd4;
      if (pc == 32'd8) regs[4] <= regs[5] + regs[3];  // ADD $4,$5,$3
    end
  end

  assign bus.i_mips_pc            = pc;
  assign bus.i_mips_register_data = regs[bus.o_debug_mips_register_number];
  assign bus.i_mips_data_memory   = 32'hD000_0000 + bus.o_debug_address;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   step_cnt = 0;
  int   xfer_cnt = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Step pulse counter
  initial forever begin
    @(negedge clk);
    if (bus.o_step === 1'b1) step_cnt++;
  end

  // Dump monitor: pops the scoreboard on every transfer, checks stability on stalls
  initial begin
    logic        stall = 1'b0;
    logic [31:0] h_data = '0;
    logic [31:0] h_addr = '0;
    logic [4:0]  h_rn = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (stall && bus.o_dump_valid) begin
        chk("stall_data", bus.o_dump_data, h_data);
        chk("stall_addr", bus.o_debug_address, h_addr);
        chk("stall_regnum", 32'(bus.o_debug_mips_register_number), 32'(h_rn));
      end
      if (bus.o_dump_valid && bus.i_dump_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", bus.o_dump_data, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          chk("dump_data", bus.o_dump_data, e.data);
          if (e.is_mem) chk("dump_addr", bus.o_debug_address, e.addr);
          else chk("dump_regnum", 32'(bus.o_debug_mips_register_number), 32'(e.rn));
        end
      end
      stall  = bus.o_dump_valid && !bus.i_dump_ready;
      h_data = bus.o_dump_data;
      h_addr = bus.o_debug_address;
      h_rn   = bus.o_debug_mips_register_number;
    end
  end

  task automatic push_dump(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '0;
      if (i < 32) begin
        e.rn   = 5'(i);
        e.data = (i == 4) ? 32'h4000_0008 : 32'hA000_0000 + i;
      end else begin
        e.is_mem = 1'b1;
        e.addr   = 32'((i - 32) * 4);
        e.data   = 32'hD000_0000 + 32'((i - 32) * 4);
      end
      exp_q.push_back(e);
    end
  endtask

  // Call at #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] c, input logic [15:0] arg);
    logic ok = 1'b0;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = c;
    bus.i_cmd_arg   = arg;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.o_cmd_ready;
    end
    if (!ok) chk("cmd_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && bus.o_busy; i++) begin
      @(posedge clk); #1;
    end
    chk("idle_reached", 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    int s0;
    int x0;
    int k;
    logic [3:0] pat;
    pat = 4'b1001;
    bus.i_cmd_valid  = 1'b0;
    bus.i_cmd        = CmdStop;
    bus.i_cmd_arg    = '0;
    bus.i_bp_enable  = 1'b0;
    bus.i_bp_pc      = '0;
    bus.i_dump_ready = 1'b1;
    model_init = 1'b1;
    pc_load    = 1'b1;
    pc_val     = 32'd0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_step", 32'(bus.o_step), 32'd0);
    chk("rst_dump_valid", 32'(bus.o_dump_valid), 32'd0);
    chk("rst_halted", 32'(bus.o_halted_bp), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_regnum", 32'(bus.o_debug_mips_register_number), 32'd0);
    chk("rst_addr", bus.o_debug_address, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; model_init = 1'b0; pc_load = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.o_cmd_ready), 32'd1);
    @(posedge clk); #1;

    // STEP_N 4 from PC 0
    s0 = step_cnt;
    send(CmdStep, 16'd4);
    repeat (6) @(posedge clk); #1;
    chk("step4_pulses", 32'(step_cnt - s0), 32'd4);
    chk("step4_pc", pc, 32'd16);
    chk("step4_busy", 32'(bus.o_busy), 32'd0);

    // STEP_N 0
    s0 = step_cnt;
    send(CmdStep, 16'd0);
    @(negedge clk);
    chk("step0_step", 32'(bus.o_step), 32'd0);
    chk("step0_busy_in", 32'(bus.o_busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("step0_busy_out", 32'(bus.o_busy), 32'd0);
    chk("step0_pulses", 32'(step_cnt - s0), 32'd0);
    @(posedge clk); #1;

    // RUN then STOP three cycles later
    s0 = step_cnt;
    send(CmdRun, 16'd0);
    repeat (2) @(posedge clk); #1;
    send(CmdStop, 16'd0);
    chk("runstop_pulses", 32'(step_cnt - s0), 32'd3);
    chk("runstop_busy", 32'(bus.o_busy), 32'd0);

    // RUN to breakpoint at PC 20
    pc_load = 1'b1; pc_val = 32'd0;
    @(posedge clk); #1;
    pc_load = 1'b0;
    bus.i_bp_enable = 1'b1;
    bus.i_bp_pc     = 32'd20;
    s0 = step_cnt;
    send(CmdRun, 16'd0);
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("bp_pulses", 32'(step_cnt - s0), 32'd5);
    chk("bp_pc", pc, 32'd20);
    chk("bp_step_low", 32'(bus.o_step), 32'd0);
    chk("bp_halted", 32'(bus.o_halted_bp), 32'd1);
    chk("bp_busy", 32'(bus.o_busy), 32'd0);
    @(posedge clk); #1;
    send(CmdStop, 16'd0);
    @(negedge clk);
    chk("halted_cleared", 32'(bus.o_halted_bp), 32'd0);
    @(posedge clk); #1;
    bus.i_bp_enable = 1'b0;

    // Full dump, ready always high
    push_dump(48);
    s0 = step_cnt;
    x0 = xfer_cnt;
    bus.i_dump_ready = 1'b1;
    send(CmdDump, 16'd0);
    wait_idle(200);
    chk("dump1_words", 32'(xfer_cnt - x0), 32'd48);
    chk("dump1_queue", 32'(exp_q.size()), 32'd0);
    chk("dump1_no_step", 32'(step_cnt - s0), 32'd0);

    // Full dump with ready pattern 1,0,0,1
    push_dump(48);
    x0 = xfer_cnt;
    send(CmdDump, 16'd0);
    k = 0;
    while (bus.o_busy && k < 600) begin
      bus.i_dump_ready = pat[k % 4];
      @(posedge clk); #1;
      k++;
    end
    bus.i_dump_ready = 1'b1;
    chk("dump2_idle", 32'(bus.o_busy), 32'd0);
    chk("dump2_words", 32'(xfer_cnt - x0), 32'd48);
    chk("dump2_queue", 32'(exp_q.size()), 32'd0);

    // Reset at word 10 of a dump, then a fresh dump restarts at register 0
    push_dump(10);
    x0 = xfer_cnt;
    send(CmdDump, 16'd0);
    k = 0;
    while ((xfer_cnt - x0) < 10 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("dump3_prefix", 32'(xfer_cnt - x0), 32'd10);
    rst = 1'b1;
    bus.i_dump_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_valid", 32'(bus.o_dump_valid), 32'd0);
    chk("abort_busy", 32'(bus.o_busy), 32'd0);
    chk("abort_regnum", 32'(bus.o_debug_mips_register_number), 32'd0);
    chk("abort_queue", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_dump_ready = 1'b1;
    push_dump(48);
    x0 = xfer_cnt;
    send(CmdDump, 16'd0);
    wait_idle(200);
    chk("dump4_words", 32'(xfer_cnt - x0), 32'd48);
    chk("dump4_queue", 32'(exp_q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
